// File: rtl/music_pkg.sv
// ---------------------------------------------------------------------------
// music_pkg
// Shared types and constants for the music command sequencer.
//   - parse_state_t : UART frame parser states
//   - disp_state_t  : player dispatcher states
//   - note_pair_t   : one buffered note/duration pair
//   - HDR_BYTE_DEF  : default frame start byte
// Optional feature macro: MUSIC_CMD_CHKSUM_EN (adds the checksum byte/state).
// ---------------------------------------------------------------------------
package music_pkg;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hAA;

  typedef enum logic [1:0] {
    P_HDR,
    P_NOTE,
`ifdef MUSIC_CMD_CHKSUM_EN
    P_TIME,
    P_SUM
`else
    P_TIME
`endif
  } parse_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_ISSUE,
    D_WAIT_RISE,
    D_PLAY
  } disp_state_t;

  // "duration" carries the frame's time byte.
  typedef struct packed {
    logic [7:0] note;
    logic [7:0] duration;
  } note_pair_t;

  localparam int PAIR_W = $bits(note_pair_t);

  // Expected value of the checksum byte for a note/time pair.
  function automatic logic [7:0] pair_checksum(input logic [7:0] note,
                                               input logic [7:0] duration);
    return note ^ duration;
  endfunction

endpackage

// File: rtl/music_pair_fifo.sv
// ---------------------------------------------------------------------------
// music_pair_fifo
// Synchronous FIFO of note_pair_t with registered read data.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wr_data   write request / pair to store (ignored when full unless
//                   a pop happens in the same cycle)
//   pop             read request; rd_data updates on the following edge and
//                   then holds until the next pop
//   full, empty     status
//   level           entries currently stored (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module music_pair_fifo
  import music_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PAIR_W-1:0]        wr_data,
  output logic [PAIR_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  note_pair_t       mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  note_pair_t       rd_data_reg;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  // A push into a full FIFO is accepted only if the head leaves this cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Storage carries no reset so it maps onto block RAM; when full, the write
  // and read hit the same slot and the read returns the old head.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_data_reg <= mem[rd_ptr_reg];
      end
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = rd_data_reg;
  assign level   = count_reg;

endmodule

// File: rtl/music_cmd_seq.sv
// ---------------------------------------------------------------------------
// music_cmd_seq
// Parses UART byte frames into note/time pairs, buffers them, and hands them
// one at a time to the tone player.
// Ports:
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   rx_data, rx_valid       received byte and its one-cycle strobe
//   music_busy              player busy (flow control)
//   music_en                one-cycle start pulse to the player
//   music_note, music_time  current pair, stable from en until next dispatch
//   fifo_level              pairs buffered (registered)
//   frame_err               one-cycle pulse: bad checksum, timeout, overflow
// Macro MUSIC_CMD_CHKSUM_EN: defined -> 4-byte frames (AA,note,time,note^time)
// with checksum check; undefined -> 3-byte frames (AA,note,time).
// ---------------------------------------------------------------------------
module music_cmd_seq
  import music_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 16,
  parameter int         BYTE_TIMEOUT = 12000,
  parameter int         BUSY_WAIT    = 16,
  parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEF
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          music_busy,
  output logic                          music_en,
  output logic [7:0]                    music_note,
  output logic [7:0]                    music_time,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err
);

  localparam int TW = $clog2(BYTE_TIMEOUT + 1);
  localparam int WW = $clog2(BUSY_WAIT + 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(BYTE_TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(BUSY_WAIT - 1);

  parse_state_t      p_state_reg, p_state_next;
  disp_state_t       d_state_reg, d_state_next;
  logic [7:0]        note_reg, dur_reg;
  logic              push_reg, push_next;
  logic              note_ld, dur_ld, chk_err, timeout;
  logic [TW-1:0]     to_cnt_reg;
  logic [WW-1:0]     wait_cnt_reg;
  logic              frame_err_reg;
  logic              fifo_pop, fifo_full, fifo_empty, drop;
  note_pair_t        wr_pair, rd_pair;
  logic [PAIR_W-1:0] rd_bits;

  // ------------------------------------------------------------ parser ----
  // Timeout only matters mid-frame; a byte in the same cycle wins.
  assign timeout = (p_state_reg != P_HDR) && !rx_valid && (to_cnt_reg == TO_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      p_state_reg <= P_HDR;
    end else begin
      p_state_reg <= p_state_next;
    end
  end

  always_comb begin
    p_state_next = p_state_reg;
    if (timeout) begin
      p_state_next = P_HDR;
    end else if (rx_valid) begin
      case (p_state_reg)
        P_HDR:   if (rx_data == HDR_BYTE) p_state_next = P_NOTE;
        P_NOTE:  p_state_next = P_TIME;
`ifdef MUSIC_CMD_CHKSUM_EN
        P_TIME:  p_state_next = P_SUM;
`else
        P_TIME:  p_state_next = P_HDR;
`endif
        default: p_state_next = P_HDR;
      endcase
    end
  end

  always_comb begin
    note_ld   = 1'b0;
    dur_ld    = 1'b0;
    push_next = 1'b0;
    chk_err   = 1'b0;
    if (rx_valid) begin
      case (p_state_reg)
        P_NOTE: note_ld = 1'b1;
        P_TIME: begin
          dur_ld = 1'b1;
`ifndef MUSIC_CMD_CHKSUM_EN
          push_next = 1'b1;
`endif
        end
`ifdef MUSIC_CMD_CHKSUM_EN
        P_SUM: begin
          if (rx_data == pair_checksum(note_reg, dur_reg)) begin
            push_next = 1'b1;
          end else begin
            chk_err = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      note_reg      <= '0;
      dur_reg       <= '0;
      push_reg      <= 1'b0;
      to_cnt_reg    <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      if (note_ld) note_reg <= rx_data;
      if (dur_ld)  dur_reg  <= rx_data;
      // Push is issued one cycle after the final byte, from the latched pair.
      push_reg <= push_next;
      if (rx_valid || (p_state_reg == P_HDR) || timeout) begin
        to_cnt_reg <= '0;
      end else begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
      frame_err_reg <= timeout | chk_err | drop;
    end
  end

  assign wr_pair   = '{note: note_reg, duration: dur_reg};
  assign drop      = push_reg && fifo_full && !fifo_pop;
  assign frame_err = frame_err_reg;

  // -------------------------------------------------------------- fifo ----
  music_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .push    (push_reg),
    .pop     (fifo_pop),
    .wr_data (wr_pair),
    .rd_data (rd_bits),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign rd_pair = rd_bits;

  // -------------------------------------------------------- dispatcher ----
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      d_state_reg  <= D_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      d_state_reg <= d_state_next;
      if (d_state_reg == D_WAIT_RISE) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end else begin
        wait_cnt_reg <= '0;
      end
    end
  end

  always_comb begin
    d_state_next = d_state_reg;
    case (d_state_reg)
      D_IDLE:      if (!fifo_empty && !music_busy) d_state_next = D_ISSUE;
      D_ISSUE:     d_state_next = D_WAIT_RISE;
      // A player that never raises busy is treated as having finished.
      D_WAIT_RISE: begin
        if (music_busy) begin
          d_state_next = D_PLAY;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          d_state_next = D_IDLE;
        end
      end
      D_PLAY:      if (!music_busy) d_state_next = D_IDLE;
      default:     d_state_next = D_IDLE;
    endcase
  end

  // The FIFO's registered read data is the held note/time output: it is
  // loaded by the pop in D_IDLE and is valid during D_ISSUE onwards.
  always_comb begin
    fifo_pop = (d_state_reg == D_IDLE) && !fifo_empty && !music_busy;
    music_en = (d_state_reg == D_ISSUE);
  end

  assign music_note = rd_pair.note;
  assign music_time = rd_pair.duration;

endmodule

// File: tb/tb_music_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_music_cmd_seq
// Directed bench for music_cmd_seq. Frame length follows MUSIC_CMD_CHKSUM_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_music_cmd_seq;

  localparam int BUSY_WAIT = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       music_busy;
  logic       music_en;
  logic [7:0] music_note;
  logic [7:0] music_time;
  logic [4:0] fifo_level;
  logic       frame_err;

  // Player model selection: 0 = busy from manual_busy, 1 = 10-cycle note
  // after each en, 2 = never busy.
  int   mode;
  logic manual_busy;
  int   auto_cnt;

  int tests_run = 0;
  int failed    = 0;

  // Monitor log of en pulses.
  int         cyc = 0;
  int         en_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] note_log [64];
  logic [7:0] time_log [64];
  int         en_cyc   [64];

  always #5 clk = ~clk;

  assign music_busy = (mode == 1) ? (auto_cnt != 0) :
                      (mode == 2) ? 1'b0 : manual_busy;

  music_cmd_seq dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .music_busy (music_busy),
    .music_en   (music_en),
    .music_note (music_note),
    .music_time (music_time),
    .fifo_level (fifo_level),
    .frame_err  (frame_err)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (music_en) begin
      if (en_cnt < 64) begin
        note_log[en_cnt] = music_note;
        time_log[en_cnt] = music_time;
        en_cyc[en_cnt]   = cyc;
      end
      en_cnt++;
    end
    if (frame_err) err_cnt++;
  end

  always @(negedge clk) begin
    if (music_en)          auto_cnt = 10;
    else if (auto_cnt > 0) auto_cnt--;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] n, input logic [7:0] t);
    send_byte(8'hAA);
    send_byte(n);
    send_byte(t);
`ifdef MUSIC_CMD_CHKSUM_EN
    send_byte(n ^ t);
`endif
  endtask

  task automatic wait_en(input int target, input int budget, input string tag);
    int guard = 0;
    while (en_cnt < target && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    chk(tag, (guard < budget) ? 1 : 0, 1);
  endtask

  initial begin
    int e0, r0;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    manual_busy = 1'b0; mode = 0; auto_cnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_en",    music_en,   0);
    chk("rst_note",  music_note, 0);
    chk("rst_time",  music_time, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_err",   frame_err,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single good frame, idle player: push one cycle after last byte,
    // en two cycles after the push.
    e0 = en_cnt;
    send_frame(8'h21, 8'h08);
    chk("t1_lvl_push_cyc", fifo_level, 0);
    @(negedge clk);
    chk("t1_lvl_one", fifo_level, 1);
    @(negedge clk);
    chk("t1_en", music_en, 1);
    chk("t1_note", music_note, 8'h21);
    chk("t1_time", music_time, 8'h08);
    chk("t1_lvl_zero", fifo_level, 0);
    @(negedge clk);
    chk("t1_en_single", music_en, 0);
    repeat (25) @(negedge clk);
    chk("t1_en_count", en_cnt - e0, 1);

`ifdef MUSIC_CMD_CHKSUM_EN
    // Bad checksum: one error pulse, nothing queued.
    e0 = en_cnt; r0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h21); send_byte(8'h08); send_byte(8'h00);
    chk("t2_err_pulse", frame_err, 1);
    @(negedge clk);
    chk("t2_err_end", frame_err, 0);
    repeat (5) @(negedge clk);
    chk("t2_lvl", fifo_level, 0);
    chk("t2_no_en", en_cnt - e0, 0);
    chk("t2_err_count", err_cnt - r0, 1);
`else
    // Bytes without a header are ignored silently.
    e0 = en_cnt; r0 = err_cnt;
    send_byte(8'h55); send_byte(8'h21); send_byte(8'h08);
    repeat (5) @(negedge clk);
    chk("t2_lvl", fifo_level, 0);
    chk("t2_no_en", en_cnt - e0, 0);
    chk("t2_no_err", err_cnt - r0, 0);
`endif

    // Inter-byte timeout: counter reaches 12000 on the 12001st idle cycle.
    e0 = en_cnt; r0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h21);
    repeat (12000) @(negedge clk);
    chk("t3_before_timeout", frame_err, 0);
    @(negedge clk);
    chk("t3_timeout_err", frame_err, 1);
    send_byte(8'h08); send_byte(8'h29);
    repeat (5) @(negedge clk);
    chk("t3_lvl", fifo_level, 0);
    chk("t3_no_en", en_cnt - e0, 0);
    chk("t3_err_count", err_cnt - r0, 1);

    // Fill while busy, overflow on the 17th frame, then drain in order.
    mode = 0; manual_busy = 1'b1;
    e0 = en_cnt; r0 = err_cnt;
    for (int i = 0; i < 16; i++) send_frame(8'(i + 1), 8'(8'h40 + i));
    repeat (2) @(negedge clk);
    chk("t4_lvl_full", fifo_level, 16);
    chk("t4_no_err_yet", err_cnt - r0, 0);
    send_frame(8'h77, 8'h77);
    repeat (2) @(negedge clk);
    chk("t4_lvl_sat", fifo_level, 16);
    chk("t4_overflow_err", err_cnt - r0, 1);
    chk("t4_no_en_busy", en_cnt - e0, 0);
    mode = 1;
    wait_en(e0 + 16, 1000, "t4_drain_bound");
    repeat (30) @(negedge clk);
    chk("t4_en_count", en_cnt - e0, 16);
    chk("t4_lvl_empty", fifo_level, 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t4_note_%0d", k), note_log[e0 + k], 8'(k + 1));
      chk($sformatf("t4_time_%0d", k), time_log[e0 + k], 8'(8'h40 + k));
    end

    // Player never raises busy: each note ends after the BUSY_WAIT window
    // (en, BUSY_WAIT wait cycles, idle/pop, next en => BUSY_WAIT+2 apart).
    mode = 2;
    e0 = en_cnt;
    send_frame(8'h31, 8'h01);
    send_frame(8'h32, 8'h02);
    send_frame(8'h33, 8'h03);
    wait_en(e0 + 3, 200, "t5_bound");
    repeat (5) @(negedge clk);
    chk("t5_en_count", en_cnt - e0, 3);
    chk("t5_gap1", en_cyc[e0 + 1] - en_cyc[e0], BUSY_WAIT + 2);
    chk("t5_gap2", en_cyc[e0 + 2] - en_cyc[e0 + 1], BUSY_WAIT + 2);
    chk("t5_note3", note_log[e0 + 2], 8'h33);
    chk("t5_lvl", fifo_level, 0);

    // Reset during D_PLAY with five pairs queued.
    mode = 0; manual_busy = 1'b0;
    e0 = en_cnt;
    send_frame(8'h5A, 8'h33);
    wait_en(e0 + 1, 20, "t6_first_en_bound");
    manual_busy = 1'b1;
    for (int i = 0; i < 5; i++) send_frame(8'(8'h60 + i), 8'h11);
    repeat (3) @(negedge clk);
    chk("t6_lvl5", fifo_level, 5);
    chk("t6_note_held", music_note, 8'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_en", music_en, 0);
    chk("t6_rst_note", music_note, 0);
    chk("t6_rst_time", music_time, 0);
    chk("t6_rst_lvl", fifo_level, 0);
    chk("t6_rst_err", frame_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    manual_busy = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_lvl_after", fifo_level, 0);
    chk("t6_no_en_after", en_cnt - e0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
